// File: rtl/csr_regfile.sv
// -----------------------------------------------------------------------------
// csr_regfile -- architectural machine-mode CSR storage for the RV64 core.
//
// Holds mstatus, mtvec, mscratch, mepc, mcause, mtval, mcycle and mhartid and
// presents them as one registered csr_pack_t bundle for the CSR read selector.
// Applies CSR instruction writes (RW/RS/RC), trap entry and mret, runs the
// free-running mcycle counter, tracks the privilege mode and produces a
// registered one-cycle PC redirect pulse for trap/mret.
//
// Per-cycle priority: trap_valid > mret_valid > csr_we. Losers are dropped.
//
// Optional feature macro: CSR_WARL_CHECK_EN
//   defined   -> CSR writes are legalised (mstatus keeps MIE/MPIE/MPP with
//                MPP=10 coerced to 00, mtvec modes 2/3 coerced to 0,
//                mepc[1:0] forced to 0).
//   undefined -> writable CSRs store the full 64-bit written value.
//
// Parameters:
//   HART_ID     value returned in mhartid (read-only)
//   RESET_PRIV  privilege mode after reset
//
// Ports:
//   clk            in   core clock
//   reset          in   asynchronous active-low reset
//   csr_we         in   CSR instruction commit this cycle
//   csr_waddr      in   target CSR address
//   csr_op         in   00 none, 01 RW, 10 RS, 11 RC
//   csr_wdata      in   rs1/zimm operand
//   trap_valid     in   exception/interrupt commit
//   trap_cause     in   mcause value (bit63 = interrupt)
//   trap_tval      in   mtval value
//   trap_pc        in   faulting PC, goes to mepc
//   mret_valid     in   mret commit
//   csr_o          out  full registered CSR bundle
//   priv_o         out  current privilege mode
//   redirect_valid out  one-cycle pulse: fetch must jump
//   redirect_pc    out  jump target, held until the next redirect
// -----------------------------------------------------------------------------
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    localparam logic [1:0] CSR_OP_NONE = 2'b00;
    localparam logic [1:0] CSR_OP_RW   = 2'b01;
    localparam logic [1:0] CSR_OP_RS   = 2'b10;
    localparam logic [1:0] CSR_OP_RC   = 2'b11;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_M = 2'b11;

    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;
    // Bits of mstatus that survive a legalised write: MIE, MPIE, MPP[12:11].
    localparam logic [63:0] MSTATUS_WMASK = 64'h0000_0000_0000_1888;

    typedef struct packed {
        logic [63:0] mstatus;
        logic [63:0] mtvec;
        logic [63:0] mscratch;
        logic [63:0] mepc;
        logic [63:0] mcause;
        logic [63:0] mtval;
        logic [63:0] mcycle;
        logic [63:0] mhartid;
    } csr_pack_t;

endpackage

module csr_regfile
    import csr_pkg::*;
#(
    parameter logic [63:0] HART_ID    = 64'd0,
    parameter logic [1:0]  RESET_PRIV = 2'b11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        csr_we,
    input  logic [11:0] csr_waddr,
    input  logic [1:0]  csr_op,
    input  logic [63:0] csr_wdata,
    input  logic        trap_valid,
    input  logic [63:0] trap_cause,
    input  logic [63:0] trap_tval,
    input  logic [63:0] trap_pc,
    input  logic        mret_valid,
    output csr_pack_t   csr_o,
    output logic [1:0]  priv_o,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc
);

    csr_pack_t   csr_q, csr_d;
    logic [1:0]  priv_q, priv_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [63:0] redirect_pc_q, redirect_pc_d;

    logic [63:0] old_val;
    logic [63:0] new_val;
    logic [63:0] legal_val;
    logic        addr_writable;
    logic        write_en;
    logic [63:0] trap_base;
    logic [63:0] trap_target;

    // Current value of the addressed CSR; mhartid and unknown addresses are
    // flagged non-writable so the write is silently dropped.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned -- that is what keeps latches from appearing.
        old_val       = '0;
        addr_writable = 1'b1;
        case (csr_waddr)
            CSR_MSTATUS:  old_val = csr_q.mstatus;
            CSR_MTVEC:    old_val = csr_q.mtvec;
            CSR_MSCRATCH: old_val = csr_q.mscratch;
            CSR_MEPC:     old_val = csr_q.mepc;
            CSR_MCAUSE:   old_val = csr_q.mcause;
            CSR_MTVAL:    old_val = csr_q.mtval;
            CSR_MCYCLE:   old_val = csr_q.mcycle;
            default:      addr_writable = 1'b0;
        endcase
    end

    always_comb begin
        new_val = old_val;
        case (csr_op)
            CSR_OP_RW: new_val = csr_wdata;
            CSR_OP_RS: new_val = old_val | csr_wdata;
            CSR_OP_RC: new_val = old_val & ~csr_wdata;
            default:   new_val = old_val;
        endcase
    end

`ifdef CSR_WARL_CHECK_EN
    always_comb begin
        legal_val = new_val;
        case (csr_waddr)
            CSR_MSTATUS: begin
                legal_val = new_val & MSTATUS_WMASK;
                if (legal_val[12:11] == 2'b10) legal_val[12:11] = PRIV_U;
            end
            CSR_MTVEC:   if (new_val[1]) legal_val[1:0] = 2'b00;
            CSR_MEPC:    legal_val[1:0] = 2'b00;
            default:     legal_val = new_val;
        endcase
    end
`else
    assign legal_val = new_val;
`endif

    // Trap and mret win the cycle; a CSR write only lands when neither fires.
    assign write_en = csr_we && (csr_op != CSR_OP_NONE) && addr_writable
                      && !trap_valid && !mret_valid;

    // Vectored mode only applies to interrupts; cause bit 63 is the flag and
    // drops out of the offset through the shift.
    assign trap_base   = {csr_q.mtvec[63:2], 2'b00};
    assign trap_target = (csr_q.mtvec[1:0] == 2'b01 && trap_cause[63])
                         ? trap_base + {trap_cause[61:0], 2'b00}
                         : trap_base;

    always_comb begin
        csr_d            = csr_q;
        csr_d.mhartid    = HART_ID;
        csr_d.mcycle     = csr_q.mcycle + 64'd1;
        priv_d           = priv_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;

        if (trap_valid) begin
            csr_d.mepc                  = trap_pc;
            csr_d.mcause                = trap_cause;
            csr_d.mtval                 = trap_tval;
            csr_d.mstatus[MSTATUS_MPIE] = csr_q.mstatus[MSTATUS_MIE];
            csr_d.mstatus[MSTATUS_MIE]  = 1'b0;
            csr_d.mstatus[12:11]        = priv_q;
            priv_d                      = PRIV_M;
            redirect_valid_d            = 1'b1;
            redirect_pc_d               = trap_target;
        end else if (mret_valid) begin
            csr_d.mstatus[MSTATUS_MIE]  = csr_q.mstatus[MSTATUS_MPIE];
            csr_d.mstatus[MSTATUS_MPIE] = 1'b1;
            csr_d.mstatus[12:11]        = PRIV_U;
            priv_d                      = csr_q.mstatus[12:11];
            redirect_valid_d            = 1'b1;
            redirect_pc_d               = csr_q.mepc;
        end else if (write_en) begin
            case (csr_waddr)
                CSR_MSTATUS:  csr_d.mstatus  = legal_val;
                CSR_MTVEC:    csr_d.mtvec    = legal_val;
                CSR_MSCRATCH: csr_d.mscratch = legal_val;
                CSR_MEPC:     csr_d.mepc     = legal_val;
                CSR_MCAUSE:   csr_d.mcause   = legal_val;
                CSR_MTVAL:    csr_d.mtval    = legal_val;
                // A written mcycle replaces this cycle's increment.
                CSR_MCYCLE:   csr_d.mcycle   = legal_val;
                default:      ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csr_q            <= '0;
            csr_q.mhartid    <= HART_ID;
            priv_q           <= RESET_PRIV;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            csr_q            <= csr_d;
            priv_q           <= priv_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign csr_o          = csr_q;
    assign priv_o         = priv_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_csr_regfile.sv
// -----------------------------------------------------------------------------
// tb_csr_regfile -- scoreboard bench for csr_regfile.
//
// The driver applies one transaction per cycle and updates an architectural
// model (CSRs held in an associative array keyed by address); the expected
// post-edge state is queued. A monitor on the falling edge pops one entry per
// cycle and compares every CSR, priv and the redirect outputs.
// -----------------------------------------------------------------------------
module tb_csr_regfile;
    import csr_pkg::*;

    localparam logic [63:0] HART = 64'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [1:0]  csr_op;
    logic [63:0] csr_wdata;
    logic        trap_valid;
    logic [63:0] trap_cause;
    logic [63:0] trap_tval;
    logic [63:0] trap_pc;
    logic        mret_valid;
    csr_pack_t   csr_o;
    logic [1:0]  priv_o;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    always #5 clk = ~clk;

    csr_regfile #(.HART_ID(HART), .RESET_PRIV(2'b11)) dut (
        .clk            (clk),
        .reset          (reset),
        .csr_we         (csr_we),
        .csr_waddr      (csr_waddr),
        .csr_op         (csr_op),
        .csr_wdata      (csr_wdata),
        .trap_valid     (trap_valid),
        .trap_cause     (trap_cause),
        .trap_tval      (trap_tval),
        .trap_pc        (trap_pc),
        .mret_valid     (mret_valid),
        .csr_o          (csr_o),
        .priv_o         (priv_o),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    typedef struct {
        logic [63:0] mstatus, mtvec, mscratch, mepc, mcause, mtval, mcycle, mhartid;
        logic [1:0]  priv;
        logic        rv;
        logic [63:0] rpc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Architectural model
    logic [63:0] m_csr [logic [11:0]];
    logic [1:0]  m_priv;
    logic [63:0] m_rpc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_writable(input logic [11:0] a);
        return a == 12'h300 || a == 12'h305 || a == 12'h340 || a == 12'h341 ||
               a == 12'h342 || a == 12'h343 || a == 12'hB00;
    endfunction

    task automatic model_reset();
        m_csr[12'h300] = 0; m_csr[12'h305] = 0; m_csr[12'h340] = 0;
        m_csr[12'h341] = 0; m_csr[12'h342] = 0; m_csr[12'h343] = 0;
        m_csr[12'hB00] = 0; m_csr[12'hF14] = HART;
        m_priv = 2'b11;
        m_rpc  = 0;
    endtask

    function automatic logic [63:0] legalise(input logic [11:0] a, input logic [63:0] v);
        logic [63:0] r;
        r = v;
`ifdef CSR_WARL_CHECK_EN
        if (a == 12'h300) begin
            r = v & ((64'd1 << 3) | (64'd1 << 7) | (64'd3 << 11));
            if (((r >> 11) & 64'd3) == 64'd2) r = r - (64'd2 << 11);
        end else if (a == 12'h305) begin
            if ((r % 4) >= 2) r = r - (r % 4);
        end else if (a == 12'h341) begin
            r = r - (r % 4);
        end
`else
        if (a == 12'hFFF) r = v;
`endif
        return r;
    endfunction

    // One cycle of stimulus: drive, advance the model, queue the expectation.
    task automatic cycle(input logic we, input logic [11:0] addr, input logic [1:0] op,
                         input logic [63:0] wd, input logic tv, input logic [63:0] cause,
                         input logic [63:0] tval, input logic [63:0] pc, input logic mv);
        logic [63:0] st, nv, base, cyc;
        bit          rv, cyc_written;
        exp_t        e;
        @(negedge clk);
        #1;
        reset = 1'b1;
        csr_we = we; csr_waddr = addr; csr_op = op; csr_wdata = wd;
        trap_valid = tv; trap_cause = cause; trap_tval = tval; trap_pc = pc;
        mret_valid = mv;

        rv = 0;
        cyc_written = 0;
        cyc = m_csr[12'hB00];
        st  = m_csr[12'h300];
        if (tv) begin
            base = m_csr[12'h305] - (m_csr[12'h305] % 4);
            if ((m_csr[12'h305] % 4) == 1 && cause[63])
                m_rpc = base + 4 * (cause % (64'd1 << 63));
            else
                m_rpc = base;
            m_csr[12'h341] = pc;
            m_csr[12'h342] = cause;
            m_csr[12'h343] = tval;
            st[7] = st[3];
            st[3] = 1'b0;
            st[12:11] = m_priv;
            m_csr[12'h300] = st;
            m_priv = 2'b11;
            rv = 1;
        end else if (mv) begin
            m_rpc = m_csr[12'h341];
            m_priv = st[12:11];
            st[3] = st[7];
            st[7] = 1'b1;
            st[12:11] = 2'b00;
            m_csr[12'h300] = st;
            rv = 1;
        end else if (we && op != 2'b00 && is_writable(addr)) begin
            case (op)
                2'b01:   nv = wd;
                2'b10:   nv = m_csr[addr] | wd;
                default: nv = m_csr[addr] & ~wd;
            endcase
            m_csr[addr] = legalise(addr, nv);
            cyc_written = (addr == 12'hB00);
        end
        if (!cyc_written) m_csr[12'hB00] = cyc + 1;

        e.mstatus = m_csr[12'h300]; e.mtvec  = m_csr[12'h305]; e.mscratch = m_csr[12'h340];
        e.mepc    = m_csr[12'h341]; e.mcause = m_csr[12'h342]; e.mtval    = m_csr[12'h343];
        e.mcycle  = m_csr[12'hB00]; e.mhartid = m_csr[12'hF14];
        e.priv = m_priv; e.rv = rv; e.rpc = m_rpc;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 12'h0, 2'b00, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic csrw(input logic [11:0] a, input logic [1:0] op, input logic [63:0] d);
        cycle(1, a, op, d, 0, 0, 0, 0, 0);
    endtask

    task automatic trap(input logic [63:0] cause, input logic [63:0] pc, input logic [63:0] tval);
        cycle(0, 12'h0, 2'b00, 0, 1, cause, tval, pc, 0);
    endtask

    task automatic mret();
        cycle(0, 12'h0, 2'b00, 0, 0, 0, 0, 0, 1);
    endtask

    // Monitor: outputs are presented every cycle; compare on the falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("mstatus",  csr_o.mstatus,  mon_e.mstatus);
            check("mtvec",    csr_o.mtvec,    mon_e.mtvec);
            check("mscratch", csr_o.mscratch, mon_e.mscratch);
            check("mepc",     csr_o.mepc,     mon_e.mepc);
            check("mcause",   csr_o.mcause,   mon_e.mcause);
            check("mtval",    csr_o.mtval,    mon_e.mtval);
            check("mcycle",   csr_o.mcycle,   mon_e.mcycle);
            check("mhartid",  csr_o.mhartid,  mon_e.mhartid);
            check("priv",     {62'd0, priv_o}, {62'd0, mon_e.priv});
            check("redirect_valid", {63'd0, redirect_valid}, {63'd0, mon_e.rv});
            check("redirect_pc", redirect_pc, mon_e.rpc);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mhartid"}, csr_o.mhartid, HART);
        check({tag, "_mcycle"},  csr_o.mcycle, 64'd0);
        check({tag, "_mstatus"}, csr_o.mstatus, 64'd0);
        check({tag, "_priv"},    {62'd0, priv_o}, 64'd3);
        check({tag, "_rv"},      {63'd0, redirect_valid}, 64'd0);
        check({tag, "_rpc"},     redirect_pc, 64'd0);
    endtask

    initial begin
        int          pick;
        logic [11:0] addrs [9];
        addrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                  12'hB00, 12'hF14, 12'h7C0};

        reset = 1'b0;
        csr_we = 0; csr_waddr = 0; csr_op = 0; csr_wdata = 0;
        trap_valid = 0; trap_cause = 0; trap_tval = 0; trap_pc = 0; mret_valid = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");

        // Idle after release: mcycle reaches 10, no redirect, priv M.
        idle(10);

        // Direct-mode trap.
        csrw(12'h305, 2'b01, 64'h8000_0000);
        trap(64'd2, 64'h8000_0100, 64'hdead);
        idle(2);

        // Vectored interrupt with MIE set.
        csrw(12'h300, 2'b10, 64'h8);
        csrw(12'h305, 2'b01, 64'h8000_0001);
        trap(64'h8000_0000_0000_0007, 64'h8000_0200, 64'h0);
        idle(1);

        // Drop to U via mret, trap from U, then mret back to U.
        csrw(12'h300, 2'b11, 64'h1800);
        mret();
        csrw(12'h300, 2'b10, 64'h8);
        trap(64'd8, 64'h4000_0040, 64'h0);
        mret();
        idle(1);

        // Trap wins over mret and a simultaneous CSR write.
        csrw(12'h340, 2'b01, 64'h11);
        cycle(1, 12'h340, 2'b01, 64'h5, 1, 64'd3, 64'h77, 64'h9000, 1);
        idle(1);

        // mret wins over a CSR write; back-to-back trap then mret.
        cycle(1, 12'h340, 2'b01, 64'h6, 0, 0, 0, 0, 1);
        trap(64'd5, 64'h1234_5670, 64'h1);
        mret();

        // RS/RC, ignored writes, mcycle load and wrap.
        csrw(12'h340, 2'b01, 64'h0);
        csrw(12'h340, 2'b10, 64'hF0);
        csrw(12'h340, 2'b11, 64'h30);
        csrw(12'hF14, 2'b01, 64'hFFFF);
        csrw(12'h7C0, 2'b01, 64'hFFFF);
        csrw(12'h340, 2'b00, 64'h1);
        csrw(12'hB00, 2'b01, 64'd100);
        idle(1);
        csrw(12'hB00, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
        idle(2);

        // Legalisation-sensitive writes (plain storage when the feature is off).
        csrw(12'h341, 2'b01, 64'h1003);
        csrw(12'h305, 2'b01, 64'h8000_0003);
        csrw(12'h305, 2'b01, 64'h8000_0002);
        csrw(12'h300, 2'b01, 64'hFFFF_FFFF_FFFF_F7FF);
        mret();
        idle(1);

        // Reset mid-operation with a trap presented: it must be discarded.
        @(negedge clk);
        #1;
        reset = 1'b0;
        trap_valid = 1'b1; trap_pc = 64'hABC0; trap_cause = 64'd1; mret_valid = 1'b1;
        model_reset();
        @(negedge clk);
        #1;
        check_reset_outputs("midreset");
        idle(3);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            pick = int'($urandom_range(0, 8));
            cycle($urandom_range(0, 1) == 1, addrs[pick], 2'($urandom_range(0, 3)),
                  {$urandom, $urandom},
                  $urandom_range(0, 15) == 0,
                  {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 59'd0, 4'($urandom)},
                  {$urandom, $urandom}, {$urandom, $urandom},
                  $urandom_range(0, 15) == 0);
        end
        idle(1);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
